// File: rtl/error_checking_if.sv
// Receive-side checker bus: word-under-check in, error mask and counters out.
// The link side (master) drives the word and the clear; the checker (slave)
// returns the registered result.
interface error_checking_if #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) ();

   logic             q_valid;
   logic [WIDTH-1:0] question;
   logic             err_clr;
   logic [WIDTH-1:0] answer;
   logic             a_valid;
   logic             mismatch;
   logic [CNT_W-1:0] err_count;

   modport master (
      output q_valid,
      output question,
      output err_clr,
      input  answer,
      input  a_valid,
      input  mismatch,
      input  err_count
   );

   modport slave (
      input  q_valid,
      input  question,
      input  err_clr,
      output answer,
      output a_valid,
      output mismatch,
      output err_count
   );

endinterface

// File: rtl/error_checking.sv
// Sequence-integrity checker for an incrementing test pattern.
// Each valid word is compared with an internal expected counter; the result
// (XOR error mask, mismatch flag, saturating error count) appears one cycle
// later, straight from flops. The expected counter advances per valid word,
// not per cycle, and optionally re-aligns to the received word on a miss.
module error_checking #(
   parameter int WIDTH  = 4,
   parameter int CNT_W  = 8,
   parameter int RESYNC = 1
) (
   input logic              clk,
   input logic              rst,
   error_checking_if.slave  bus
);

   logic [WIDTH-1:0] expected_q, expected_d;
   logic [WIDTH-1:0] answer_q,   answer_d;
   logic             a_valid_q,  a_valid_d;
   logic             mismatch_q, mismatch_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   logic             word_miss;
   logic [CNT_W-1:0] count_base;

   // Miss is only meaningful on a valid word; gaps never count as errors.
   always_comb begin
      word_miss = bus.q_valid && (bus.question != expected_q);
   end

   // Result path and expected-counter advance.
   always_comb begin
      expected_d = expected_q;
      answer_d   = answer_q;
      a_valid_d  = 1'b0;
      mismatch_d = 1'b0;
      if (bus.q_valid) begin
         answer_d   = bus.question ^ expected_q;
         a_valid_d  = 1'b1;
         mismatch_d = word_miss;
         if (word_miss && (RESYNC != 0)) begin
            expected_d = bus.question + WIDTH'(1);
         end else begin
            expected_d = expected_q + WIDTH'(1);
         end
      end
   end

   // Error counter: clear is applied first, then a miss on the same edge is
   // counted on top of it; the count sticks at all-ones rather than wrapping.
   always_comb begin
      count_base  = bus.err_clr ? '0 : err_count_q;
      err_count_d = count_base;
      if (word_miss && (count_base != '1)) begin
         err_count_d = count_base + CNT_W'(1);
      end
   end

   // State registers with synchronous reset overriding all inputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         expected_q  <= '0;
         answer_q    <= '0;
         a_valid_q   <= 1'b0;
         mismatch_q  <= 1'b0;
         err_count_q <= '0;
      end else begin
         expected_q  <= expected_d;
         answer_q    <= answer_d;
         a_valid_q   <= a_valid_d;
         mismatch_q  <= mismatch_d;
         err_count_q <= err_count_d;
      end
   end

   assign bus.answer    = answer_q;
   assign bus.a_valid   = a_valid_q;
   assign bus.mismatch  = mismatch_q;
   assign bus.err_count = err_count_q;

endmodule

// File: tb/tb_error_checking.sv
// Bench for error_checking: three instances share stimulus
//   [0] defaults (CNT_W=8, RESYNC=1), [1] CNT_W=2 for saturation, [2] RESYNC=0.
// A behavioural model tracks the expected word per instance with plain
// integer arithmetic and predicts every registered output.
module tb_error_checking;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       q_valid = 1'b0;
   logic [3:0] question = 4'd0;
   logic       err_clr = 1'b0;

   int total = 0;
   int bad   = 0;

   error_checking_if #(.WIDTH(4), .CNT_W(8)) bus_m ();
   error_checking_if #(.WIDTH(4), .CNT_W(2)) bus_s ();
   error_checking_if #(.WIDTH(4), .CNT_W(8)) bus_f ();

   assign bus_m.q_valid = q_valid;  assign bus_m.question = question;  assign bus_m.err_clr = err_clr;
   assign bus_s.q_valid = q_valid;  assign bus_s.question = question;  assign bus_s.err_clr = err_clr;
   assign bus_f.q_valid = q_valid;  assign bus_f.question = question;  assign bus_f.err_clr = err_clr;

   error_checking #(.WIDTH(4), .CNT_W(8), .RESYNC(1)) u_main (.clk(clk), .rst(rst), .bus(bus_m));
   error_checking #(.WIDTH(4), .CNT_W(2), .RESYNC(1)) u_sat  (.clk(clk), .rst(rst), .bus(bus_s));
   error_checking #(.WIDTH(4), .CNT_W(8), .RESYNC(0)) u_free (.clk(clk), .rst(rst), .bus(bus_f));

   always #5 clk = ~clk;

   logic [3:0] obs_ans [3];
   logic       obs_av  [3];
   logic       obs_mm  [3];
   logic [7:0] obs_cnt [3];

   assign obs_ans[0] = bus_m.answer;   assign obs_av[0] = bus_m.a_valid;
   assign obs_ans[1] = bus_s.answer;   assign obs_av[1] = bus_s.a_valid;
   assign obs_ans[2] = bus_f.answer;   assign obs_av[2] = bus_f.a_valid;
   assign obs_mm[0]  = bus_m.mismatch; assign obs_cnt[0] = bus_m.err_count;
   assign obs_mm[1]  = bus_s.mismatch; assign obs_cnt[1] = {6'd0, bus_s.err_count};
   assign obs_mm[2]  = bus_f.mismatch; assign obs_cnt[2] = bus_f.err_count;

   // Reference model state, one slot per instance.
   int m_exp [3];
   int m_ans [3];
   int m_av  [3];
   int m_mm  [3];
   int m_cnt [3];
   int resync_of [3] = '{1, 1, 0};
   int cmax_of   [3] = '{255, 3, 255};

   // Apply one cycle of stimulus, clock it, then advance the model.
   task automatic step(input logic v, input logic [3:0] q, input logic clr);
      int c;
      bit miss;
      q_valid  = v;
      question = q;
      err_clr  = clr;
      @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         if (rst) begin
            m_exp[k] = 0; m_ans[k] = 0; m_av[k] = 0; m_mm[k] = 0; m_cnt[k] = 0;
         end else begin
            miss = v && (int'(q) != m_exp[k]);
            c = clr ? 0 : m_cnt[k];
            if (miss) c = (c + 1 > cmax_of[k]) ? cmax_of[k] : c + 1;
            m_cnt[k] = c;
            if (v) begin
               m_ans[k] = int'(q) ^ m_exp[k];
               m_mm[k]  = miss ? 1 : 0;
               m_av[k]  = 1;
               if (miss && resync_of[k] != 0) m_exp[k] = (int'(q) + 1) % 16;
               else                           m_exp[k] = (m_exp[k] + 1) % 16;
            end else begin
               m_av[k] = 0;
               m_mm[k] = 0;
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b1, 4'($urandom_range(0, 15)), 1'b1);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      // Build up some state first so reset has something to clear.
      rst = 1'b0;
      step(1'b1, 4'd9, 1'b0);
      step(1'b1, 4'd3, 1'b0);
      do_reset();
      for (int k = 0; k < 3; k++) begin
         total++;
         if (obs_ans[k] !== 4'd0 || obs_av[k] !== 1'b0 || obs_mm[k] !== 1'b0 || obs_cnt[k] !== 8'd0) begin
            bad++;
            $display("FAIL reset[%0d]: got ans=%0d av=%b mm=%b cnt=%0d, want all zero",
                     k, obs_ans[k], obs_av[k], obs_mm[k], obs_cnt[k]);
         end
      end
   endtask

   task automatic test_clean_sweep();
      do_reset();
      for (int i = 0; i < 15; i++) begin
         step(1'b1, 4'(i), 1'b0);
         total++;
         if (obs_ans[0] !== 4'd0 || obs_mm[0] !== 1'b0 || obs_av[0] !== 1'b1 || obs_cnt[0] !== 8'd0) begin
            bad++;
            $display("FAIL sweep q=%0d: got ans=%0d mm=%b av=%b cnt=%0d, want 0/0/1/0",
                     i, obs_ans[0], obs_mm[0], obs_av[0], obs_cnt[0]);
         end
      end
   endtask

   task automatic test_corruption();
      do_reset();
      step(1'b1, 4'd0, 1'b0);
      step(1'b1, 4'd1, 1'b0);
      step(1'b1, 4'd2, 1'b0);
      step(1'b1, 4'd7, 1'b0);
      total++;
      if (obs_ans[0] !== 4'b0100 || obs_mm[0] !== 1'b1 || obs_cnt[0] !== 8'd1) begin
         bad++;
         $display("FAIL corrupt7: got ans=%b mm=%b cnt=%0d, want 0100/1/1", obs_ans[0], obs_mm[0], obs_cnt[0]);
      end
      step(1'b1, 4'd8, 1'b0);
      total++;
      if (obs_ans[0] !== 4'd0 || obs_mm[0] !== 1'b0 || obs_cnt[0] !== 8'd1) begin
         bad++;
         $display("FAIL resync8: got ans=%b mm=%b cnt=%0d, want 0000/0/1", obs_ans[0], obs_mm[0], obs_cnt[0]);
      end
      // Free-running instance still expects 4 after the miss, so 8 misses too.
      total++;
      if (obs_ans[2] !== 4'b1100 || obs_mm[2] !== 1'b1 || obs_cnt[2] !== 8'd2) begin
         bad++;
         $display("FAIL freerun8: got ans=%b mm=%b cnt=%0d, want 1100/1/2", obs_ans[2], obs_mm[2], obs_cnt[2]);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      for (int i = 0; i < 17; i++) begin
         step(1'b1, 4'(i % 16), 1'b0);
         total++;
         if (obs_mm[0] !== 1'b0 || obs_ans[0] !== 4'd0 || obs_mm[2] !== 1'b0) begin
            bad++;
            $display("FAIL wrap i=%0d: got mm=%b ans=%0d free_mm=%b, want 0/0/0", i, obs_mm[0], obs_ans[0], obs_mm[2]);
         end
      end
   endtask

   task automatic test_gaps();
      do_reset();
      step(1'b1, 4'd0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b0, 4'($urandom_range(0, 15)), 1'b0);
         total++;
         if (obs_av[0] !== 1'b0 || obs_ans[0] !== 4'd0 || obs_mm[0] !== 1'b0) begin
            bad++;
            $display("FAIL gap%0d: got av=%b ans=%0d mm=%b, want 0/0/0", i, obs_av[0], obs_ans[0], obs_mm[0]);
         end
      end
      step(1'b1, 4'd1, 1'b0);
      total++;
      if (obs_av[0] !== 1'b1 || obs_ans[0] !== 4'd0 || obs_mm[0] !== 1'b0) begin
         bad++;
         $display("FAIL after_gap: got av=%b ans=%0d mm=%b, want 1/0/0", obs_av[0], obs_ans[0], obs_mm[0]);
      end
   endtask

   task automatic test_saturation();
      int want [5] = '{1, 2, 3, 3, 3};
      do_reset();
      // Expected starts at 0 and re-syncs to 6; a constant 5 misses every time.
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 4'd5, 1'b0);
         total++;
         if (obs_cnt[1] !== 8'(want[i])) begin
            bad++;
            $display("FAIL sat%0d: got cnt=%0d, want %0d", i, obs_cnt[1], want[i]);
         end
      end
      step(1'b0, 4'd0, 1'b1);
      total++;
      if (obs_cnt[1] !== 8'd0 || obs_cnt[0] !== 8'd0) begin
         bad++;
         $display("FAIL clr_alone: got sat_cnt=%0d main_cnt=%0d, want 0/0", obs_cnt[1], obs_cnt[0]);
      end
      step(1'b1, 4'd5, 1'b1);
      total++;
      if (obs_cnt[1] !== 8'd1 || obs_mm[1] !== 1'b1) begin
         bad++;
         $display("FAIL clr_with_err: got cnt=%0d mm=%b, want 1/1", obs_cnt[1], obs_mm[1]);
      end
   endtask

   task automatic test_reset_midstream();
      do_reset();
      step(1'b1, 4'd0, 1'b0);
      step(1'b1, 4'd1, 1'b0);
      step(1'b1, 4'd2, 1'b0);
      do_reset();
      total++;
      if (obs_av[0] !== 1'b0 || obs_ans[0] !== 4'd0 || obs_mm[0] !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset: got av=%b ans=%0d mm=%b, want 0/0/0", obs_av[0], obs_ans[0], obs_mm[0]);
      end
      step(1'b1, 4'd0, 1'b0);
      total++;
      if (obs_mm[0] !== 1'b0 || obs_ans[0] !== 4'd0) begin
         bad++;
         $display("FAIL post_reset0: got ans=%0d mm=%b, want 0/0", obs_ans[0], obs_mm[0]);
      end
      do_reset();
      step(1'b1, 4'd3, 1'b0);
      total++;
      if (obs_ans[0] !== 4'b0011 || obs_mm[0] !== 1'b1) begin
         bad++;
         $display("FAIL post_reset3: got ans=%b mm=%b, want 0011/1", obs_ans[0], obs_mm[0]);
      end
   endtask

   task automatic test_random();
      logic       v, c;
      logic [3:0] q;
      do_reset();
      for (int n = 0; n < 400; n++) begin
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 19) == 0);
         // Mostly send the in-sequence word so long clean runs occur too.
         if ($urandom_range(0, 3) != 0) q = 4'(m_exp[0]);
         else                           q = 4'($urandom_range(0, 15));
         rst = ($urandom_range(0, 99) == 0);
         step(v, q, c);
         rst = 1'b0;
         for (int k = 0; k < 3; k++) begin
            total++;
            if (obs_ans[k] !== 4'(m_ans[k]) || obs_av[k] !== 1'(m_av[k]) ||
                obs_mm[k] !== 1'(m_mm[k]) || obs_cnt[k] !== 8'(m_cnt[k])) begin
               bad++;
               $display("FAIL random n=%0d dut%0d: got ans=%0d av=%b mm=%b cnt=%0d, want ans=%0d av=%0d mm=%0d cnt=%0d",
                        n, k, obs_ans[k], obs_av[k], obs_mm[k], obs_cnt[k],
                        m_ans[k], m_av[k], m_mm[k], m_cnt[k]);
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) begin
         m_exp[k] = 0; m_ans[k] = 0; m_av[k] = 0; m_mm[k] = 0; m_cnt[k] = 0;
      end
      test_reset();
      test_clean_sweep();
      test_corruption();
      test_wrap();
      test_gaps();
      test_saturation();
      test_reset_midstream();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/error_checking.md
Name: error_checking

Overview:
Registered sequence-integrity checker. A 4-bit word arrives on `question` on each valid cycle and is compared against an internally tracked expected value, which is an incrementing counter. The block returns the bitwise error mask on `answer` and maintains a mismatch flag and a saturating error count. It sits at the receive side of a test/telemetry link and checks that an incrementing pattern arrives intact.

Parameters:
- WIDTH, 4, width of `question`, `answer` and the internal expected counter.
- CNT_W, 8, width of the saturating error counter.
- RESYNC, 1, on mismatch: 1 = expected re-aligns to question+1; 0 = expected keeps free-running (expected+1).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- q_valid  input  1  `question` is valid this cycle.
- question  input  WIDTH  received word under check.
- err_clr  input  1  synchronous clear of `err_count` only.
- answer  output  WIDTH  registered error mask, equal to question XOR expected.
- a_valid  output  1  `answer` and `mismatch` are valid this cycle.
- mismatch  output  1  registered; 1 when the sampled word differed from expected.
- err_count  output  CNT_W  number of mismatched words; saturates at all-ones.

Behaviour:
- Reset, when rst=1 at a clock edge:
  - answer=0, a_valid=0, mismatch=0, err_count=0.
  - Internal expected=0.
  - rst overrides every other input.
- Latency: 1 cycle. A word sampled at edge N produces answer/a_valid/mismatch after edge N, valid during cycle N+1.
- On an edge with q_valid=1:
  - answer <= question ^ expected.
  - mismatch <= (question != expected).
  - a_valid <= 1.
  - expected update:
    - match: expected <= expected+1, wrapping modulo 2^WIDTH (15 -> 0 for WIDTH=4).
    - mismatch with RESYNC=1: expected <= question+1 (mod 2^WIDTH).
    - mismatch with RESYNC=0: expected <= expected+1.
- On an edge with q_valid=0:
  - a_valid <= 0 and mismatch <= 0.
  - answer holds its last value.
  - expected holds.
- err_count rules:
  - Increments by 1 on each mismatch sample; holds at 2^CNT_W-1 once reached, with no wrap.
  - err_clr=1 with no mismatch this edge: err_count <= 0.
  - err_clr=1 with a mismatch on the same edge: err_count <= 1. The clear applies first, then the new error is counted.
  - err_clr has no effect on expected, answer, a_valid or mismatch.
- All outputs are driven directly from flops; there is no combinational path from inputs to outputs.
- Gaps in q_valid do not advance expected. The sequence is counted per valid word, not per cycle.

Test Plan:
1. Clean sweep: after reset, drive q_valid=1 with question=0,1,...,14, one per cycle. Every result has answer=0 and mismatch=0; a_valid=1 from the cycle after the first sample; err_count stays 0.
2. Single-bit corruption, RESYNC=1: after sending 0,1,2, send 7 and then 8. The cycle after 7 shows answer=4'b0100, mismatch=1, err_count=1. The word 8 then gives answer=0 and mismatch=0 because of the re-sync.
3. Wrap-around: send 0..15 then 0 with q_valid=1 continuously. There are no mismatches, and the expected value wraps 15 -> 0.
4. Valid gaps: send 0, then 3 cycles with q_valid=0, then 1. a_valid=0 during the gap and answer holds 0; the word 1 checks clean.
5. Saturation and clear (CNT_W=2): force 5 consecutive mismatches and check that err_count goes 1,2,3,3,3. Assert err_clr alone and check err_count=0. Assert err_clr together with a mismatch and check err_count=1.
6. Reset mid-stream: after 0,1,2, assert rst for 1 cycle. Outputs go to 0 and a_valid=0. The next word 0 checks clean; a word of 3 instead would give answer=4'b0011, mismatch=1.
